id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register sitting directly downstream of the decode-stage datapath controller.
//  Captures the decoded control word plus operands each cycle, or inserts a bubble.
//  Owns two hazards:
//   - load-use: 1-cycle stall.
//   - multi-cycle multiply (AluOp 5'b01100): holds EX for MUL_CYCLES cycles.
//  Drives Stall back to the PC and IF/ID register, and EX_Advance forward to the EX/MEM write enable.
// PARAMETERS
//  MUL_CYCLES  4   cycles a multiply occupies EX (>=1); 1 disables the MUL state
//  CNT_W       3   width of the multiply counter; must hold MUL_CYCLES
// PORTS
//  Clock          in   1   single clock, rising edge
//  Reset_n        in   1   asynchronous, active-low reset
//  ID_WriteEnable in   1   StageWriteEnable[0] from decode; 0 = no valid instruction in ID
//  ID_Flush       in   1   kill the instruction currently in ID
//  ID_RegWrite, ID_AluSrc, ID_MemWrite, ID_MemRead, ID_Branch, ID_Jump, ID_SignExt  in  1 each  decoded controls
//  ID_RegDest, ID_MemToReg, ID_ByteSel  in  2 each  decoded selects
//  ID_AluOp       in   5   ALU controller opcode
//  ID_ReadData1/2 in   32  register file read data
//  ID_Imm         in   32  extended immediate
//  ID_PCPlus4     in   32  PC+4 of the ID instruction
//  ID_Rs, ID_Rt, ID_Rd  in  5 each  register specifiers
//  EX_*           out  (same widths)  registered copies of every ID_* above, excluding WriteEnable and Flush
//  EX_Valid       out  1   EX holds a real instruction, not a bubble
//  EX_Advance     out  1   EX contents are final this cycle; EX/MEM must latch them
//  Stall          out  1   hold PC and IF/ID this cycle (combinational)
// BEHAVIOUR
//  Reset (Reset_n=0, async)
//   - All EX_* = 0, EX_Valid = 0, state = RUN, Count = 0.
//   - Stall and EX_Advance therefore read 0.
//  Bubble
//   - All EX_* control bits, selects, AluOp, data and specifiers load 0; EX_Valid = 0.
//  LoadUse (combinational)
//   - Condition: EX_Valid & EX_MemRead & EX_Rt!=0 & ID_WriteEnable & (EX_Rt==ID_Rs | EX_Rt==ID_Rt).
//  State RUN
//   - Stall = LoadUse.
//   - EX_Advance = EX_Valid.
//   - Edge load priority:
//     1. ID_Flush -> bubble.
//     2. !ID_WriteEnable -> bubble.
//     3. LoadUse -> bubble; ID is held upstream via Stall and re-presented next cycle.
//     4. Otherwise load ID, EX_Valid <= 1.
//   - If a valid ID_AluOp==5'b01100 is loaded and MUL_CYCLES>1: next state MUL, Count <= MUL_CYCLES.
//  State MUL
//   - All EX_* held.
//   - Count decrements each edge.
//   - While Count>1: Stall = 1, EX_Advance = 0.
//   - When Count==1 (final cycle):
//     - Stall = 0, EX_Advance = 1.
//     - At the edge, load from ID using the RUN priority rules (LoadUse cannot fire; EX holds a mul).
//     - Next state RUN, or MUL again if another multiply is loaded.
//   - ID_Flush while Count>1 does not affect the mul in EX. It is honoured on the final edge if still asserted.
//  Latency and throughput
//   - ID to EX is 1 cycle.
//   - Multiply occupies EX for exactly MUL_CYCLES cycles; back-to-back multiplies give no idle gap.
//  Zero register
//   - EX_Rt==0 never triggers LoadUse.
//  Reset mid-MUL
//   - Abort immediately to RUN with a bubble; Stall deasserts asynchronously.
// TESTING
//  1. Reset_n=0 with random ID inputs -> all EX_*=0, Stall=0, EX_Advance=0. Release: the next edge loads ID.
//  2. LW rt=5 followed by ADD rs=5 ->
//     - Stall=1 for exactly 1 cycle; EX gets a bubble (EX_RegWrite=0, EX_Valid=0).
//     - The ADD enters EX on the next edge. Repeat with rt=0 -> no stall.
//  3. MUL (AluOp 01100) with MUL_CYCLES=4 ->
//     - Stall high for 3 cycles; EX_Advance low 3 cycles then high 1.
//     - The following ADDI enters EX on the 4th edge.
//  4. ID_Flush=1 with ID_RegWrite=1, ID_MemWrite=1 -> EX_RegWrite=0, EX_MemWrite=0, EX_Valid=0 next cycle.
//     ID_WriteEnable=0 gives the same bubble.
//  5. Two back-to-back MULs -> 8 consecutive EX cycles, EX_Advance pulses at cycles 4 and 8, no idle bubble.
//  6. Reset_n pulsed low at MUL Count=2 -> state RUN, EX cleared, Stall=0 without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use and multi-cycle multiply hazard control
//
// Ports
//   Clock, Reset_n        rising-edge clock, asynchronous active-low reset
//   ID_WriteEnable        a valid instruction is present in ID
//   ID_Flush              kill the instruction currently in ID
//   ID_* (controls/data)  decoded control word, operands and register specifiers from decode
//   EX_* (controls/data)  registered copies of the ID_* control word and operands
//   EX_Valid              EX holds a real instruction rather than a bubble
//   EX_Advance            EX contents are final this cycle; the EX/MEM register must latch them
//   Stall                 hold PC and IF/ID this cycle (combinational)
module id_ex_stage #(
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 3
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        ID_WriteEnable,
   input  logic        ID_Flush,
   input  logic        ID_RegWrite,
   input  logic        ID_AluSrc,
   input  logic        ID_MemWrite,
   input  logic        ID_MemRead,
   input  logic        ID_Branch,
   input  logic        ID_Jump,
   input  logic        ID_SignExt,
   input  logic [1:0]  ID_RegDest,
   input  logic [1:0]  ID_MemToReg,
   input  logic [1:0]  ID_ByteSel,
   input  logic [4:0]  ID_AluOp,
   input  logic [31:0] ID_ReadData1,
   input  logic [31:0] ID_ReadData2,
   input  logic [31:0] ID_Imm,
   input  logic [31:0] ID_PCPlus4,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic [4:0]  ID_Rd,
   output logic        EX_RegWrite,
   output logic        EX_AluSrc,
   output logic        EX_MemWrite,
   output logic        EX_MemRead,
   output logic        EX_Branch,
   output logic        EX_Jump,
   output logic        EX_SignExt,
   output logic [1:0]  EX_RegDest,
   output logic [1:0]  EX_MemToReg,
   output logic [1:0]  EX_ByteSel,
   output logic [4:0]  EX_AluOp,
   output logic [31:0] EX_ReadData1,
   output logic [31:0] EX_ReadData2,
   output logic [31:0] EX_Imm,
   output logic [31:0] EX_PCPlus4,
   output logic [4:0]  EX_Rs,
   output logic [4:0]  EX_Rt,
   output logic [4:0]  EX_Rd,
   output logic        EX_Valid,
   output logic        EX_Advance,
   output logic        Stall
);
   localparam int         W      = 161;
   localparam logic [4:0] MUL_OP = 5'b01100;

   typedef enum logic {RUN, MUL} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [W-1:0]     r_ex;
   logic             r_valid;
   logic [W-1:0]     w_id;
   logic             w_load_use;
   logic             w_final;
   logic             w_load;
   logic             w_mul;

   // The whole control word travels as one vector so bubble and load are single assignments.
   assign w_id = {ID_RegWrite, ID_AluSrc, ID_MemWrite, ID_MemRead, ID_Branch, ID_Jump, ID_SignExt,
                  ID_RegDest, ID_MemToReg, ID_ByteSel, ID_AluOp,
                  ID_ReadData1, ID_ReadData2, ID_Imm, ID_PCPlus4, ID_Rs, ID_Rt, ID_Rd};

   assign {EX_RegWrite, EX_AluSrc, EX_MemWrite, EX_MemRead, EX_Branch, EX_Jump, EX_SignExt,
           EX_RegDest, EX_MemToReg, EX_ByteSel, EX_AluOp,
           EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4, EX_Rs, EX_Rt, EX_Rd} = r_ex;

   assign EX_Valid = r_valid;

   // A multiply sitting in EX is never a load, so the hazard is only looked for in RUN.
   assign w_load_use = (r_state == RUN) && r_valid && EX_MemRead && (EX_Rt != 5'd0) &&
                       ID_WriteEnable && ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));

   // EX accepts new contents in RUN and on the last cycle of a multiply.
   assign w_final = (r_state == RUN) || (r_count == CNT_W'(1));
   assign w_load  = ID_WriteEnable && !ID_Flush && !w_load_use;
   assign w_mul   = w_load && (ID_AluOp == MUL_OP) && (MUL_CYCLES > 1);

   assign Stall      = (r_state == MUL) ? (r_count > CNT_W'(1)) : w_load_use;
   assign EX_Advance = (r_state == MUL) ? (r_count == CNT_W'(1)) : r_valid;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= RUN;
         r_count <= '0;
         r_ex    <= '0;
         r_valid <= 1'b0;
      end else if (w_final) begin
         r_ex    <= w_load ? w_id : '0;
         r_valid <= w_load;
         r_state <= w_mul ? MUL : RUN;
         r_count <= w_mul ? CNT_W'(MUL_CYCLES) : '0;
      end else begin
         r_count <= r_count - CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage against an occupancy-based reference model
module tb_id_ex_stage;
   localparam int         MC     = 4;
   localparam logic [4:0] MUL_OP = 5'b01100;

   typedef struct packed {
      logic        regwrite, alusrc, memwrite, memread, branch, jump, signext;
      logic [1:0]  regdest, memtoreg, bytesel;
      logic [4:0]  aluop;
      logic [31:0] rd1, rd2, imm, pc4;
      logic [4:0]  rs, rt, rd;
   } word_t;

   logic  clk = 0, rst_n = 0, we = 0, fl = 0;
   word_t id = '0;
   word_t ex;
   logic  ex_valid, ex_adv, stall;
   int    errors = 0, checks = 0;

   // Model: the instruction in EX plus how many cycles it still occupies EX (1 for everything but a multiply).
   word_t m_ex;
   bit    m_valid;
   int    m_left;

   always #5 clk = ~clk;

   id_ex_stage #(.MUL_CYCLES(MC), .CNT_W(3)) dut (
      .Clock(clk), .Reset_n(rst_n), .ID_WriteEnable(we), .ID_Flush(fl),
      .ID_RegWrite(id.regwrite), .ID_AluSrc(id.alusrc), .ID_MemWrite(id.memwrite), .ID_MemRead(id.memread),
      .ID_Branch(id.branch), .ID_Jump(id.jump), .ID_SignExt(id.signext),
      .ID_RegDest(id.regdest), .ID_MemToReg(id.memtoreg), .ID_ByteSel(id.bytesel), .ID_AluOp(id.aluop),
      .ID_ReadData1(id.rd1), .ID_ReadData2(id.rd2), .ID_Imm(id.imm), .ID_PCPlus4(id.pc4),
      .ID_Rs(id.rs), .ID_Rt(id.rt), .ID_Rd(id.rd),
      .EX_RegWrite(ex.regwrite), .EX_AluSrc(ex.alusrc), .EX_MemWrite(ex.memwrite), .EX_MemRead(ex.memread),
      .EX_Branch(ex.branch), .EX_Jump(ex.jump), .EX_SignExt(ex.signext),
      .EX_RegDest(ex.regdest), .EX_MemToReg(ex.memtoreg), .EX_ByteSel(ex.bytesel), .EX_AluOp(ex.aluop),
      .EX_ReadData1(ex.rd1), .EX_ReadData2(ex.rd2), .EX_Imm(ex.imm), .EX_PCPlus4(ex.pc4),
      .EX_Rs(ex.rs), .EX_Rt(ex.rt), .EX_Rd(ex.rd),
      .EX_Valid(ex_valid), .EX_Advance(ex_adv), .Stall(stall)
   );

   task automatic chk(input string name, input logic [160:0] act, input logic [160:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit lu();
      return m_valid && m_ex.memread && (m_ex.rt != 5'd0) && we && ((m_ex.rt == id.rs) || (m_ex.rt == id.rt));
   endfunction

   task automatic m_reset();
      m_ex = '0;
      m_valid = 0;
      m_left = 1;
   endtask

   task automatic m_step();
      if (m_left > 1) m_left--;
      else if (fl || !we || lu()) begin
         m_ex = '0;
         m_valid = 0;
         m_left = 1;
      end else begin
         m_ex = id;
         m_valid = 1;
         m_left = (id.aluop == MUL_OP) ? MC : 1;
      end
   endtask

   // Compare process: every cycle, 3 time units after the falling edge, once inputs have settled.
   initial begin
      m_reset();
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) m_reset();
         chk("m_ex", ex, m_ex);
         chk("m_valid", ex_valid, m_valid);
         chk("m_stall", stall, (m_left > 1) ? 1'b1 : lu());
         chk("m_adv", ex_adv, (m_left > 1) ? 1'b0 : (m_left == 1 && m_valid));
         @(posedge clk);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   function automatic word_t rnd();
      logic [191:0] r;
      word_t w;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      w = r[160:0];
      w.rs = 5'($urandom_range(0, 3));
      w.rt = 5'($urandom_range(0, 3));
      w.memread = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) w.aluop = MUL_OP;
      if (w.aluop == MUL_OP) w.memread = 0;
      return w;
   endfunction

   task automatic drv(input word_t w, input logic we_i, input logic fl_i);
      @(negedge clk);
      #1;
      id = w;
      we = we_i;
      fl = fl_i;
      #1;
   endtask

   word_t z, a, lw, add, mul, mul2, addi, fw;

   initial begin
      z = '0;
      // Reset with random inputs present, then release: the next edge loads ID.
      repeat (3) begin
         drv(rnd(), 1, 0);
         chk("rst_ex", ex, '0);
         chk("rst_valid", ex_valid, 0);
         chk("rst_stall", stall, 0);
         chk("rst_adv", ex_adv, 0);
      end
      a = rnd();
      a.aluop = 5'd1;
      drv(a, 1, 0);
      rst_n = 1;
      drv(z, 1, 0);
      chk("rel_load", ex, a);
      chk("rel_valid", ex_valid, 1);
      chk("rel_adv", ex_adv, 1);
      // Load-use: LW rt=5 then ADD rs=5.
      lw = z; lw.memread = 1; lw.regwrite = 1; lw.rt = 5'd5;
      add = z; add.regwrite = 1; add.rs = 5'd5; add.rt = 5'd7; add.aluop = 5'd2;
      drv(lw, 1, 0);
      drv(add, 1, 0);
      chk("lu_stall", stall, 1);
      drv(add, 1, 0);
      chk("lu_bub_rw", ex.regwrite, 0);
      chk("lu_bub_valid", ex_valid, 0);
      chk("lu_stall_off", stall, 0);
      drv(z, 1, 0);
      chk("lu_add_in", ex, add);
      chk("lu_add_valid", ex_valid, 1);
      // Same pattern through register 0 must not stall.
      lw.rt = 5'd0;
      add.rs = 5'd0;
      drv(lw, 1, 0);
      drv(add, 1, 0);
      chk("r0_stall", stall, 0);
      drv(z, 1, 0);
      chk("r0_add_in", ex, add);
      // Multiply holds EX for four cycles, ADDI follows without a gap.
      mul = z; mul.aluop = MUL_OP; mul.regwrite = 1; mul.rs = 5'd1;
      addi = z; addi.aluop = 5'd3; addi.alusrc = 1; addi.imm = 32'h1234; addi.rd = 5'd4;
      drv(mul, 1, 0);
      for (int i = 0; i < 4; i++) begin
         drv(addi, 1, 0);
         chk("mul_stall", stall, i < 3);
         chk("mul_adv", ex_adv, i == 3);
         chk("mul_hold", ex.aluop, MUL_OP);
      end
      drv(z, 1, 0);
      chk("mul_addi_in", ex, addi);
      chk("mul_addi_valid", ex_valid, 1);
      // Flush and missing write enable both yield a bubble.
      fw = z; fw.regwrite = 1; fw.memwrite = 1;
      drv(fw, 1, 1);
      drv(z, 1, 0);
      chk("fl_rw", ex.regwrite, 0);
      chk("fl_mw", ex.memwrite, 0);
      chk("fl_valid", ex_valid, 0);
      drv(fw, 0, 0);
      drv(z, 1, 0);
      chk("we_rw", ex.regwrite, 0);
      chk("we_mw", ex.memwrite, 0);
      chk("we_valid", ex_valid, 0);
      // Back-to-back multiplies: eight busy cycles, advance on the 4th and 8th.
      mul2 = mul; mul2.rd = 5'd9;
      drv(mul, 1, 0);
      for (int i = 0; i < 8; i++) begin
         drv((i < 4) ? mul2 : z, 1, 0);
         chk("b2b_adv", ex_adv, (i % 4) == 3);
         chk("b2b_valid", ex_valid, 1);
         chk("b2b_rd", ex.rd, (i < 4) ? 5'd0 : 5'd9);
      end
      // Asynchronous reset with the multiply counter at 2.
      drv(mul, 1, 0);
      drv(z, 1, 0);
      drv(z, 1, 0);
      drv(z, 1, 0);
      chk("ar_pre_stall", stall, 1);
      #2;
      rst_n = 0;
      #1;
      chk("ar_stall", stall, 0);
      chk("ar_valid", ex_valid, 0);
      chk("ar_adv", ex_adv, 0);
      chk("ar_ex", ex, '0);
      drv(z, 1, 0);
      rst_n = 1;
      // Randomized traffic checked by the compare process.
      repeat (1500) drv(rnd(), $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0);
      @(negedge clk);
      #5;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
